// File: rtl/md_pkg.sv
// Shared op codes, latency defaults and state encoding for the multiply/divide unit.
// Optional madd/maddu support is enabled by defining MDU_MADD_EN.
package md_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [OP_W-1:0] MD_MADDU = 4'd8;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

`ifdef MDU_MADD_EN
  localparam logic MD_MADD_EN = 1'b1;
`else
  localparam logic MD_MADD_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the arithmetic for a multi-cycle run.
  function automatic logic md_is_long(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      MD_MADD, MD_MADDU:                  r = MD_MADD_EN;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic md_is_valid(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      MD_NONE:          r = 1'b0;
      MD_MTHI, MD_MTLO: r = 1'b1;
      default:          r = md_is_long(op);
    endcase
    return r;
  endfunction

  function automatic logic md_is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide/multiply-accumulate datapath; wr_en drops on divide by zero.
// madd/maddu results are produced only when MDU_MADD_EN is defined.
module md_arith
  import md_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_rt,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  output logic [XLEN-1:0] o_res_hi,
  output logic [XLEN-1:0] o_res_lo,
  output logic            o_wr_en
);

  logic [2*XLEN-1:0]        w_rs_sx;
  logic [2*XLEN-1:0]        w_rt_sx;
  logic [2*XLEN-1:0]        w_prod_s;
  logic [2*XLEN-1:0]        w_prod_u;
  logic [2*XLEN-1:0]        w_acc_s;
  logic [2*XLEN-1:0]        w_acc_u;
  logic                     w_div_zero;
  logic                     w_div_ovf;
  logic [XLEN-1:0]          w_rt_sdiv;
  logic [XLEN-1:0]          w_rt_udiv;
  logic signed [XLEN-1:0]   w_quo_s;
  logic signed [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]          w_quo_u;
  logic [XLEN-1:0]          w_rem_u;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_rs_sx  = {{XLEN{i_rs[XLEN-1]}}, i_rs};
  assign w_rt_sx  = {{XLEN{i_rt[XLEN-1]}}, i_rt};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {XLEN'(0), i_rs} * {XLEN'(0), i_rt};
  assign w_acc_s  = {i_hi, i_lo} + w_prod_s;
  assign w_acc_u  = {i_hi, i_lo} + w_prod_u;

  // MIN/-1 divides by 1 instead, which yields exactly quotient MIN, remainder 0.
  assign w_div_zero = (i_rt == XLEN'(0));
  assign w_div_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);
  assign w_rt_sdiv  = (w_div_zero || w_div_ovf) ? XLEN'(1) : i_rt;
  assign w_rt_udiv  = w_div_zero ? XLEN'(1) : i_rt;
  assign w_quo_s    = $signed(i_rs) / $signed(w_rt_sdiv);
  assign w_rem_s    = $signed(i_rs) % $signed(w_rt_sdiv);
  assign w_quo_u    = i_rs / w_rt_udiv;
  assign w_rem_u    = i_rs % w_rt_udiv;

  always_comb begin
    o_res_hi = i_hi;
    o_res_lo = i_lo;
    o_wr_en  = 1'b0;
    case (i_op)
      MD_MULT: begin
        {o_res_hi, o_res_lo} = w_prod_s;
        o_wr_en = 1'b1;
      end
      MD_MULTU: begin
        {o_res_hi, o_res_lo} = w_prod_u;
        o_wr_en = 1'b1;
      end
      MD_DIV: begin
        o_res_hi = w_rem_s;
        o_res_lo = w_quo_s;
        o_wr_en  = ~w_div_zero;
      end
      MD_DIVU: begin
        o_res_hi = w_rem_u;
        o_res_lo = w_quo_u;
        o_wr_en  = ~w_div_zero;
      end
      MD_MADD: begin
        {o_res_hi, o_res_lo} = w_acc_s;
        o_wr_en = MD_MADD_EN;
      end
      MD_MADDU: begin
        {o_res_hi, o_res_lo} = w_acc_u;
        o_wr_en = MD_MADD_EN;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer: HI/LO registers, fixed-latency busy counter and D-stage stall.
// Define MDU_MADD_EN to enable madd/maddu (op 7/8); otherwise they are no-ops.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            req,
  input  logic            d_md_use,
  output logic            busy,
  output logic            stall_md,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_pend_hi;
  logic [XLEN-1:0]  r_pend_lo;
  logic             r_pend_wr;

  logic             w_long;
  logic             w_acc;
  logic             w_acc_long;
  logic             w_done;
  logic [XLEN-1:0]  w_res_hi;
  logic [XLEN-1:0]  w_res_lo;
  logic             w_res_wr;

  assign w_long     = md_is_long(op);
  assign w_acc      = start & ~req & (r_state == ST_IDLE) & md_is_valid(op);
  assign w_acc_long = w_acc & w_long;
  assign w_done     = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));

  md_arith u_arith (
    .i_op     (op),
    .i_rs     (rs_val),
    .i_rt     (rt_val),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo),
    .o_wr_en  (w_res_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc_long) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_done)     w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall covers the cycle the op enters E as well as the whole run.
  always_comb begin
    busy     = (r_state == ST_RUN);
    stall_md = d_md_use & (busy | (start & w_long));
  end

  // Result is captured at the accepting edge and committed when the count expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_acc_long) begin
        r_cnt     <= md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_wr <= w_res_wr;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_acc && (op == MD_MTHI)) r_hi <= rs_val;
      if (w_acc && (op == MD_MTLO)) r_lo <= rs_val;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios plus random traffic against a reference model.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, req, d_md_use;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .req(req), .d_md_use(d_md_use), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural HI/LO, remaining busy cycles and the pending result.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  bit          m_pwr = 1'b0;
  int          m_rem = 0;

  bit g_stall, g_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit t_long(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (MADD_ON && (o == 4'd7 || o == 4'd8));
  endfunction

  function automatic bit t_valid(input logic [3:0] o);
    return t_long(o) || o == 4'd5 || o == 4'd6;
  endfunction

  // Spec arithmetic expressed with 64-bit integer math.
  task automatic m_compute(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, acc;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {m_hi, m_lo};
    m_pwr = 1'b1;
    case (o)
      4'd1: m_pend = 64'(sa * sb);
      4'd2: m_pend = ua * ub;
      4'd3: if (b == 0) m_pwr = 1'b0;
            else m_pend = {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b == 0) m_pwr = 1'b0;
            else m_pend = {32'(ua % ub), 32'(ua / ub)};
      4'd7: m_pend = acc + 64'(sa * sb);
      default: m_pend = acc + ua * ub;
    endcase
    m_rem = (o == 4'd3 || o == 4'd4) ? 10 : 5;
  endtask

  task automatic m_edge(input bit s, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit rq, input bit rst);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pwr) {m_hi, m_lo} = m_pend;
    end else if (s && !rq && t_valid(o)) begin
      if (o == 4'd5) m_hi = a;
      else if (o == 4'd6) m_lo = a;
      else m_compute(o, a, b);
    end
  endtask

  // One clock: drive at negedge, check stall before the edge, check state after it.
  task automatic cyc(input bit s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input bit rq, input bit dm, input bit rst);
    bit e_stall;
    start = s; op = o; rs_val = a; rt_val = b; req = rq; d_md_use = dm; reset = rst;
    #1;
    e_stall = dm && ((m_rem > 0) || (s && t_long(o)));
    g_stall = stall_md;
    chk("stall_md", 32'(stall_md), 32'(e_stall));
    @(posedge clk);
    m_edge(s, o, a, b, rq, rst);
    #1;
    g_busy = busy;
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit dm, output int nbusy, output int nstall);
    nbusy = 0; nstall = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 4'd0, '0, '0, 1'b0, dm, 1'b0);
      nbusy += int'(g_busy);
      nstall += int'(g_stall);
    end
  endtask

  initial begin
    int nb, ns, nb0, ns0;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    start = 0; op = 0; rs_val = 0; rt_val = 0; req = 0; d_md_use = 0; reset = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // mult -2 * 3
    cyc(1, 4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
    nb0 = int'(g_busy);
    idle(7, 0, nb, ns);
    chk("mult_busy_cycles", 32'(nb + nb0), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // divu 100/7 with mflo waiting in D
    cyc(1, 4'd4, 32'd100, 32'd7, 0, 1, 0);
    ns0 = int'(g_stall);
    idle(13, 1, nb, ns);
    chk("divu_stall_cycles", 32'(ns + ns0), 32'd11);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    cyc(1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    idle(11, 0, nb, ns);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    cyc(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    idle(11, 0, nb, ns);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    // divide by zero leaves HI/LO alone but still runs the full latency
    cyc(1, 4'd5, 32'h11, 0, 0, 0, 0);
    cyc(1, 4'd6, 32'h22, 0, 0, 0, 0);
    cyc(1, 4'd3, 32'd5, 32'd0, 0, 0, 0);
    nb0 = int'(g_busy);
    idle(12, 0, nb, ns);
    chk("div0_busy_cycles", 32'(nb + nb0), 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // mthi cancelled by M-stage request
    cyc(1, 4'd5, 32'hDEAD, 0, 1, 0, 0);
    chk("mthi_req_hi", hi, 32'h11);
    chk("mthi_req_busy", 32'(busy), 32'h0);

    // reset on cycle 3 of a mult
    cyc(1, 4'd1, 32'd1234, 32'd5678, 0, 0, 0);
    idle(2, 0, nb, ns);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    idle(6, 0, nb, ns);
    chk("rst_mid_no_commit", 32'(nb), 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);

    // madd carry into HI (no-op when the option is off)
    cyc(1, 4'd6, 32'hFFFF_FFFF, 0, 0, 0, 0);
    cyc(1, 4'd7, 32'd1, 32'd1, 0, 1, 0);
    idle(6, 0, nb, ns);
    chk("madd_hi", hi, MADD_ON ? 32'd1 : 32'd0);
    chk("madd_lo", lo, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      cyc(1'($urandom_range(0, 1)), ro, ra, rb, $urandom_range(0, 9) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
